// File: rtl/osc_period_meter.sv
// osc_period_meter: gated BCD measurement engine for a ring oscillator.
// Period mode counts FPGA_clk cycles over win_len oscillator edges; frequency
// mode counts oscillator edges over win_len clock cycles. The result is latched
// for the 7-segment scan driver together with a saturation flag.
module osc_period_meter #(
  parameter int DIGITS      = 4,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  FPGA_clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic [WIN_W-1:0]      win_len,
  input  logic                  osc_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  gate,
  output logic                  done,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Ripple BCD increment; bit BW is the carry out of the top digit, which is
  // only set when every digit was 9.
  function automatic logic [BW:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return {c, r};
  endfunction

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   osc_prev_q;
  logic                   start_q;
  logic [BW-1:0]          live_q, live_d;
  logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   mode_sh_q, mode_sh_d;
  logic [WIN_W-1:0]       win_sh_q, win_sh_d;
  logic [BW-1:0]          bcd_out_q, bcd_out_d;
  logic                   ovf_out_q, ovf_out_d;

  logic                   osc_rise;
  logic                   launch;
  logic [BW:0]            inc_s;
  logic [BW-1:0]          live_inc_s;
  logic                   ovf_inc_s;
  logic [WIN_W-1:0]       win_next_s;
  logic                   do_bcd_s;
  logic                   do_win_s;

  assign osc_rise   = sync_q[SYNC_STAGES-1] & ~osc_prev_q;
  assign launch     = start & ~start_q;
  assign inc_s      = bcd_inc(live_q);
  // Saturate at all 9s instead of wrapping to zero.
  assign live_inc_s = inc_s[BW] ? live_q : inc_s[BW-1:0];
  assign ovf_inc_s  = ovf_q | inc_s[BW];
  assign win_next_s = win_cnt_q + {{(WIN_W-1){1'b0}}, 1'b1};

  // Synchronise the asynchronous oscillator and keep one extra flop for edge detection.
  always_ff @(posedge FPGA_clk) begin
    if (!clr) begin
      sync_q     <= '0;
      osc_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], osc_in};
      osc_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Previous start level; reset high so a start held through reset cannot launch.
  always_ff @(posedge FPGA_clk) begin
    if (!clr) begin
      start_q <= 1'b1;
    end else begin
      start_q <= start;
    end
  end

  // Next-state, counter and result-latch logic.
  always_comb begin
    state_d   = state_q;
    live_d    = live_q;
    win_cnt_d = win_cnt_q;
    ovf_d     = ovf_q;
    mode_sh_d = mode_sh_q;
    win_sh_d  = win_sh_q;
    bcd_out_d = bcd_out_q;
    ovf_out_d = ovf_out_q;
    do_bcd_s  = 1'b0;
    do_win_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          live_d    = '0;
          win_cnt_d = '0;
          ovf_d     = 1'b0;
          mode_sh_d = mode;
          win_sh_d  = (win_len == '0) ? {{(WIN_W-1){1'b0}}, 1'b1} : win_len;
          state_d   = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        // The arming edge only aligns the window; it is not counted.
        if (osc_rise) begin
          state_d = ST_MEASURE;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_MEASURE: begin
        do_bcd_s = mode_sh_q ? osc_rise : 1'b1;
        do_win_s = mode_sh_q ? 1'b1 : osc_rise;
        if (do_bcd_s) begin
          live_d = live_inc_s;
          ovf_d  = ovf_inc_s;
        end else begin
          live_d = live_q;
        end
        if (do_win_s) begin
          win_cnt_d = win_next_s;
          if (win_next_s == win_sh_q) begin
            // The closing cycle's own increment is part of the result.
            state_d   = ST_DONE;
            bcd_out_d = live_d;
            ovf_out_d = ovf_d;
          end else begin
            state_d = ST_MEASURE;
          end
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over every transition, including the latch into DONE.
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      bcd_out_d = bcd_out_q;
      ovf_out_d = ovf_out_q;
    end else begin
      state_d = state_d;
    end
  end

  // State, counters, shadow registers and latched result.
  always_ff @(posedge FPGA_clk) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      live_q    <= '0;
      win_cnt_q <= '0;
      ovf_q     <= 1'b0;
      mode_sh_q <= 1'b0;
      win_sh_q  <= {{(WIN_W-1){1'b0}}, 1'b1};
      bcd_out_q <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= live_d;
      win_cnt_q <= win_cnt_d;
      ovf_q     <= ovf_d;
      mode_sh_q <= mode_sh_d;
      win_sh_q  <= win_sh_d;
      bcd_out_q <= bcd_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign bcd_out  = bcd_out_q;
  assign overflow = ovf_out_q;
  assign busy     = (state_q == ST_ARM) || (state_q == ST_MEASURE);
  assign gate     = (state_q == ST_MEASURE);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_osc_period_meter.sv
// Directed bench for osc_period_meter with a queue-based scoreboard.
module tb_osc_period_meter;

  logic        clk;
  logic        clr;
  logic        start;
  logic        abort;
  logic        mode;
  logic [15:0] win_len;
  logic        osc_in;
  logic [15:0] bcd_out;
  logic        busy;
  logic        gate;
  logic        done;
  logic        overflow;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        ovf;
  } sb_t;

  sb_t sb_q[$];
  int  ncmp;
  int  nfail;
  int  osc_period;
  int  done_cnt;
  int  gate_cnt;
  int  busy_cnt;

  osc_period_meter #(.DIGITS(4), .WIN_W(16), .SYNC_STAGES(2)) dut (
    .FPGA_clk (clk),
    .clr      (clr),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .win_len  (win_len),
    .osc_in   (osc_in),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .gate     (gate),
    .done     (done),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Square-wave oscillator, half high / half low, stepped on falling edges.
  initial begin
    int ph;
    ph = 0;
    osc_in = 1'b0;
    forever begin
      @(negedge clk);
      ph = ph + 1;
      if (ph >= osc_period) ph = 0;
      osc_in = (ph < osc_period / 2) ? 1'b1 : 1'b0;
    end
  end

  // Output activity counters, sampled just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) done_cnt = done_cnt + 1;
      if (gate) gate_cnt = gate_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp = ncmp + 1;
    assert (obs === exp) else begin
      nfail = nfail + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input logic [15:0] obs, input logic [15:0] lo,
                           input logic [15:0] hi);
    ncmp = ncmp + 1;
    assert ((obs >= lo) && (obs <= hi)) else begin
      nfail = nfail + 1;
      $error("FAIL %s observed=%h expected=%h..%h", tag, obs, lo, hi);
    end
  endtask

  task automatic launch(input logic m, input int w);
    @(negedge clk);
    mode    = m;
    win_len = w[15:0];
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Launch one measurement, wait for done, compare against the scoreboard entry.
  task automatic run(input string tag, input logic m, input int w, input int p,
                     input logic [15:0] lo, input logic [15:0] hi, input logic eo,
                     input int exp_gate, input bit tog);
    sb_t e;
    bit  got;
    @(negedge clk);
    osc_period = p;
    done_cnt   = 0;
    gate_cnt   = 0;
    e.lo  = lo;
    e.hi  = hi;
    e.ovf = eo;
    sb_q.push_back(e);
    launch(m, w);
    got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1;
      if (tog && i == 20) start = 1'b1;
      if (tog && i == 24) start = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    e = sb_q.pop_front();
    chk_range({tag, "_bcd"}, bcd_out, e.lo, e.hi);
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_done_pulses"}, done_cnt, 32'd1);
    if (exp_gate >= 0) chk({tag, "_gate_cycles"}, gate_cnt, exp_gate);
  endtask

  initial begin
    bit seen;
    ncmp       = 0;
    nfail      = 0;
    done_cnt   = 0;
    gate_cnt   = 0;
    busy_cnt   = 0;
    osc_period = 8;
    clr        = 1'b0;
    start      = 1'b1;
    abort      = 1'b0;
    mode       = 1'b0;
    win_len    = 16'd10;

    // Reset state, with start held high throughout.
    repeat (4) @(posedge clk);
    #1;
    chk("rst_bcd", {16'd0, bcd_out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gate", {31'd0, gate}, 32'd0);

    @(negedge clk);
    clr = 1'b1;
    busy_cnt = 0;
    repeat (30) @(negedge clk);
    chk("held_start_no_launch", busy_cnt, 32'd0);
    start = 1'b0;

    // Mode 0 basic: 10 edges of period 8 -> 80 clocks.
    run("m0_basic", 1'b0, 10, 8, 16'h0080, 16'h0080, 1'b0, 80, 1'b0);
    // Start toggled mid-measure must be ignored.
    run("m0_toggle", 1'b0, 10, 8, 16'h0080, 16'h0080, 1'b0, 80, 1'b1);
    // Different pattern: period 6, 7 edges -> 42.
    run("m0_p6", 1'b0, 7, 6, 16'h0042, 16'h0042, 1'b0, 42, 1'b0);
    // Mode 1: 1000 clocks with period 10 -> about 100 edges.
    run("m1_1000", 1'b1, 1000, 10, 16'h0099, 16'h0101, 1'b0, 1000, 1'b0);
    // Mode 1 with win_len 0 behaves as a one-cycle window.
    run("m1_win0", 1'b1, 0, 8, 16'h0000, 16'h0001, 1'b0, 1, 1'b0);
    // Saturation: true count 16000.
    run("m0_ovf", 1'b0, 2000, 8, 16'h9999, 16'h9999, 1'b1, -1, 1'b0);
    // Next run clears the sticky flag and produces 80 again.
    run("m0_after_ovf", 1'b0, 10, 8, 16'h0080, 16'h0080, 1'b0, 80, 1'b0);

    // Abort mid-measure keeps the previous result.
    done_cnt = 0;
    launch(1'b0, 10);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (gate) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_gate_seen", {31'd0, seen}, 32'd1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bcd", {16'd0, bcd_out}, 32'h0080);
    @(negedge clk);
    abort = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_no_done", done_cnt, 32'd0);
    chk("abort_bcd_hold", {16'd0, bcd_out}, 32'h0080);

    // Synchronous clear mid-measure.
    launch(1'b0, 10);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (gate) begin
        seen = 1'b1;
        break;
      end
    end
    chk("clr_gate_seen", {31'd0, seen}, 32'd1);
    repeat (5) @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_outputs", {12'd0, bcd_out, overflow, done, busy, gate}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    repeat (20) @(negedge clk);
    chk("clr_stays_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
